// File: rtl/uart_tx_fifo_drain_if.sv
// Interface between the eduSOC TX FIFO look-ahead read port, the transmitter
// control (enable) and the serial line side of uart_tx_fifo_drain.
//
// Handshake: fifo_dout is valid whenever fifo_empty=0 (look-ahead word).
// A byte is transferred in exactly the cycles where fifo_re=1. fifo_re is
// only raised when fifo_empty=0 and en=1, and it acts as the pop strobe to
// the FIFO on that same rising clk edge. There is no back-pressure in the
// other direction: once popped, the byte belongs to the transmitter.
interface uart_tx_fifo_drain_if;
  logic       en;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_re;
  logic       txd;
  logic       busy;
  logic       tx_done;
  logic [2:0] dbg_state;

  // FIFO/host side
  modport master (
    output en, fifo_dout, fifo_empty,
    input  fifo_re, txd, busy, tx_done, dbg_state
  );

  // Transmitter side
  modport slave (
    input  en, fifo_dout, fifo_empty,
    output fifo_re, txd, busy, tx_done, dbg_state
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a look-ahead TX FIFO. Frames are 8 data bits,
// LSB first, optional even/odd parity and 1 or 2 stop bits. When the FIFO
// still holds data at the last stop cycle the next byte is fetched in that
// cycle, so frames run back-to-back with no idle bit in between.
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic                 clk,
  input logic                 arst,
  uart_tx_fifo_drain_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] LP_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LP_STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic        LP_HAS_PAR   = (PARITY != 0);
  localparam logic        LP_ODD_PAR   = (PARITY == 2);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_txd;

  logic        w_bit_end;
  logic        w_stop_end;
  logic        w_fetch;

  // Bit boundary and last-stop-cycle detection; fetch is allowed in IDLE or
  // on the final stop cycle, and never while reset is held so that no byte
  // is popped that the held-in-reset FSM could not capture.
  assign w_bit_end  = (r_cnt == LP_BIT_LAST);
  assign w_stop_end = (r_state == S_STOP) && w_bit_end && (r_idx == LP_STOP_LAST);
  assign w_fetch    = !arst && bus.en && !bus.fifo_empty &&
                      ((r_state == S_IDLE) || w_stop_end);

  assign bus.fifo_re   = w_fetch;
  assign bus.txd       = r_txd;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.tx_done   = w_stop_end;
  assign bus.dbg_state = r_state;

  // Frame sequencer: txd is registered and updated on the edge that enters
  // each bit, so every bit is held for exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (w_fetch) begin
            r_shift <= bus.fifo_dout;
            r_par   <= (^bus.fifo_dout) ^ LP_ODD_PAR;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_txd   <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_idx <= '0;
              if (LP_HAS_PAR) begin
                r_txd   <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == LP_STOP_LAST) begin
              r_idx <= '0;
              if (w_fetch) begin
                // Back-to-back: capture the next byte and go straight to START.
                r_shift <= bus.fifo_dout;
                r_par   <= (^bus.fifo_dout) ^ LP_ODD_PAR;
                r_txd   <= 1'b0;
                r_state <= S_START;
              end else begin
                r_txd   <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: two instances (8N1 and 8O2, 4 clks per bit)
// each fed from a simple array-based FIFO model. Expected line levels come
// from a frame model built from the byte value and the framing rules.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  uart_tx_fifo_drain_if bus0 ();
  uart_tx_fifo_drain_if bus1 ();

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk  (clk),
    .arst (arst),
    .bus  (bus0)
  );

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut1 (
    .clk  (clk),
    .arst (arst),
    .bus  (bus1)
  );

  // ---------------- FIFO models (look-ahead) ----------------
  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  int wp0 = 0;
  int wp1 = 0;
  int rp0 = 0;
  int rp1 = 0;

  // Pop on fifo_re, then present the head word and the empty flag.
  always @(posedge clk) begin
    int nrp;
    nrp = rp0;
    if (bus0.fifo_re === 1'b1 && rp0 != wp0) nrp = rp0 + 1;
    rp0 <= nrp;
    bus0.fifo_empty <= (nrp == wp0);
    bus0.fifo_dout  <= mem0[nrp % 64];
  end

  always @(posedge clk) begin
    int nrp;
    nrp = rp1;
    if (bus1.fifo_re === 1'b1 && rp1 != wp1) nrp = rp1 + 1;
    rp1 <= nrp;
    bus1.fifo_empty <= (nrp == wp1);
    bus1.fifo_dout  <= mem1[nrp % 64];
  end

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbits(input int s);
    return (s == 0) ? 10 : 12;
  endfunction

  // Line level for bit slot j of a frame carrying byte b.
  function automatic logic exp_line(input int s, input logic [7:0] b, input int j);
    int par;
    par = (s == 0) ? 0 : 2;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9 && par != 0) return ($countones(b) % 2 == 1) ? (par == 1) : (par == 2);
    return 1'b1;
  endfunction

  // {fifo_re, txd, busy, tx_done}
  function automatic logic [3:0] sig(input int s);
    if (s == 0) return {bus0.fifo_re, bus0.txd, bus0.busy, bus0.tx_done};
    return {bus1.fifo_re, bus1.txd, bus1.busy, bus1.tx_done};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input int s, input logic [7:0] b);
    if (s == 0) begin mem0[wp0 % 64] = b; wp0++; end
    else        begin mem1[wp1 % 64] = b; wp1++; end
  endtask

  task automatic set_en(input int s, input logic v);
    if (s == 0) bus0.en = v;
    else        bus1.en = v;
  endtask

  task automatic wait_re(input int s, input int budget);
    logic       seen;
    logic [3:0] o;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      o = sig(s);
      if (o[3] === 1'b1) seen = 1'b1;
    end
    chk($sformatf("fetch_seen d%0d", s), seen, 1'b1);
  endtask

  // Called right after the fetch cycle; checks every cycle of the frame.
  task automatic check_frame(input int s, input logic [7:0] b, input logic nxt, input int drop_k);
    int n;
    logic [3:0] o;
    n = nbits(s) * CPB;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == drop_k) begin
        set_en(s, 1'b0);
        #1;
      end
      o = sig(s);
      chk($sformatf("txd d%0d b%02h k%0d", s, b, k), o[2], exp_line(s, b, k / CPB));
      chk($sformatf("busy d%0d k%0d", s, k), o[1], 1'b1);
      chk($sformatf("tx_done d%0d k%0d", s, k), o[0], k == n - 1);
      chk($sformatf("fifo_re d%0d k%0d", s, k), o[3], (k == n - 1) && nxt);
    end
  endtask

  task automatic idle_check(input int s, input int cycles);
    logic [3:0] o;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      o = sig(s);
      chk($sformatf("idle_re d%0d", s), o[3], 1'b0);
      chk($sformatf("idle_txd d%0d", s), o[2], 1'b1);
      chk($sformatf("idle_busy d%0d", s), o[1], 1'b0);
      chk($sformatf("idle_done d%0d", s), o[0], 1'b0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] rb [6];
    logic [3:0] o;
    logic [7:0] b1;
    logic [7:0] b2;

    arst    = 1'b1;
    bus0.en = 1'b0;
    bus1.en = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = sig(s);
      chk($sformatf("rst_re d%0d", s), o[3], 1'b0);
      chk($sformatf("rst_txd d%0d", s), o[2], 1'b1);
      chk($sformatf("rst_busy d%0d", s), o[1], 1'b0);
      chk($sformatf("rst_done d%0d", s), o[0], 1'b0);
    end
    arst = 1'b0;
    idle_check(0, 3);

    // Single byte 8N1
    push(0, 8'h55);
    set_en(0, 1'b1);
    wait_re(0, 10);
    check_frame(0, 8'h55, 1'b0, -1);
    idle_check(0, 3);

    // Back-to-back
    push(0, 8'hA3);
    push(0, 8'h0F);
    wait_re(0, 10);
    check_frame(0, 8'hA3, 1'b1, -1);
    check_frame(0, 8'h0F, 1'b0, -1);
    idle_check(0, 2);

    // Odd parity, two stop bits
    push(1, 8'h07);
    set_en(1, 1'b1);
    wait_re(1, 10);
    check_frame(1, 8'h07, 1'b0, -1);
    idle_check(1, 2);

    // Empty with enable, then data with enable low
    idle_check(0, 100);
    set_en(0, 1'b0);
    push(0, 8'hC6);
    idle_check(0, 100);
    @(negedge clk);
    set_en(0, 1'b1);
    #1;
    o = sig(0);
    chk("fetch_on_en", o[3], 1'b1);
    check_frame(0, 8'hC6, 1'b0, -1);

    // Enable dropped during DATA with two bytes queued
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    push(0, b1);
    push(0, b2);
    wait_re(0, 10);
    check_frame(0, b1, 1'b0, CPB * 3);
    idle_check(0, $urandom_range(5, 20));
    @(negedge clk);
    set_en(0, 1'b1);
    #1;
    o = sig(0);
    chk("refetch_on_en", o[3], 1'b1);
    check_frame(0, b2, 1'b0, -1);

    // Reset during DATA bit 3
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    push(0, b1);
    push(0, b2);
    wait_re(0, 10);
    for (int k = 0; k <= 4 * CPB; k++) begin
      @(negedge clk);
      o = sig(0);
      chk($sformatf("pre_rst_txd k%0d", k), o[2], exp_line(0, b1, k / CPB));
    end
    #2;
    arst = 1'b1;
    #1;
    o = sig(0);
    chk("async_rst_txd", o[2], 1'b1);
    chk("async_rst_busy", o[1], 1'b0);
    chk("async_rst_re", o[3], 1'b0);
    chk("async_rst_done", o[0], 1'b0);
    repeat (2) @(negedge clk);
    o = sig(0);
    chk("held_rst_txd", o[2], 1'b1);
    chk("held_rst_re", o[3], 1'b0);
    arst = 1'b0;
    #1;
    o = sig(0);
    chk("post_rst_fetch", o[3], 1'b1);
    check_frame(0, b2, 1'b0, -1);

    // Random back-to-back streams on both instances
    for (int i = 0; i < 6; i++) begin
      rb[i] = 8'($urandom);
      push(1, rb[i]);
    end
    wait_re(1, 10);
    for (int i = 0; i < 6; i++) check_frame(1, rb[i], i < 5, -1);
    idle_check(1, 2);

    for (int i = 0; i < 4; i++) begin
      rb[i] = 8'($urandom);
      push(0, rb[i]);
    end
    wait_re(0, 10);
    for (int i = 0; i < 4; i++) check_frame(0, rb[i], i < 3, -1);
    idle_check(0, 2);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Serial UART transmitter that sits directly downstream of the eduSOC synchronous TX FIFO.
- Pulls bytes through the FIFO's look-ahead read port: `fifo_dout` is valid whenever `fifo_empty` is 0, and the pop is `fifo_re`.
- Serialises each byte as an 8-bit, LSB-first frame with optional parity and 1 or 2 stop bits.
- Runs back-to-back with no idle gap while the FIFO holds data; feeds the board TXD pin.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per serial bit (25 MHz / 115200); legal range 2..65535.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- arst  input  1  asynchronous reset, active-high.
- en  input  1  transmitter enable; gates fetching of new bytes only.
- fifo_dout  input  8  look-ahead data from upstream FIFO; valid when fifo_empty=0.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_re  output  1  one-cycle pop strobe to upstream FIFO.
- txd  output  1  serial line, idle high, registered.
- busy  output  1  1 while a frame is in progress (state != IDLE).
- tx_done  output  1  one-cycle pulse on the final clk of the last stop bit.

Behaviour:
- Reset (async, any time, including mid-frame):
  - txd=1, fifo_re=0, busy=0, tx_done=0.
  - State=IDLE; baud counter=0; bit index=0.
  - No partial frame resumes after reset is released.
- States: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE or START.
- Fetch:
  - In IDLE, when en=1 and fifo_empty=0, drive fifo_re=1 for exactly that cycle.
  - In the same cycle, capture fifo_dout into the shift register and compute parity over the captured byte.
  - Next state is START. fifo_re is never asserted when fifo_empty=1.
- Baud counter:
  - 16-bit; cleared on every state entry; counts 0..CLKS_PER_BIT-1.
  - Each bit is held on txd for exactly CLKS_PER_BIT cycles.
- Line levels by state:
  - START: txd=0.
  - DATA: shift register bit 0 first; shift right after each bit; 8 bits, bit index 0..7.
  - PARITY: even = XOR of data bits; odd = its inverse.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Latency: txd falls on the clk edge after the fetch cycle, i.e. one cycle after fifo_re.
- Frame length: N = (10 + (PARITY!=0) + (STOP_BITS-1)) * CLKS_PER_BIT cycles, measured from the txd fall to the end of the stop bit(s).
- Back-to-back:
  - On the final stop cycle, tx_done=1.
  - If en=1 and fifo_empty=0 in that cycle, fifo_re=1, the new byte is captured and the next state is START (no IDLE cycle). Frame pitch is then exactly N.
  - Otherwise the next state is IDLE.
- en deasserted mid-frame: the current frame completes unchanged; no further fetch until en=1.
- fifo_empty rising while a frame is in flight: no effect, because data was already captured.
- busy is combinational from the state register: 1 from the START entry through the last stop cycle.

Test Plan:
1. Single byte framing. Setup: CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, FIFO holds 0x55, en=1. Required: one fifo_re pulse; txd samples per bit = 0,1,0,1,0,1,0,1,0,1; 40 cycles; tx_done pulses once; busy=0 afterwards.
2. Back-to-back. Setup: FIFO holds 0xA3, 0x0F. Required: two fifo_re pulses exactly 40 cycles apart; no txd-high idle cycle between frames; second frame data bits = 1,1,1,1,0,0,0,0.
3. Parity and two stop bits. Setup: PARITY=2 (odd), STOP_BITS=2, byte 0x07. Required: parity bit=0 (three ones plus odd parity gives 0); frame = 12*4 = 48 cycles.
4. Empty and disabled. Cases: fifo_empty=1 with en=1, and fifo_empty=0 with en=0, each for 100 cycles. Required: fifo_re never asserted; txd=1 and busy=0 throughout.
5. en drop mid-frame. Setup: deassert en during DATA with 2 bytes queued. Required: current frame completes; no second fifo_re until en returns; the fetch then occurs in the first IDLE cycle with en=1.
6. Reset mid-frame. Setup: assert arst during DATA bit 3. Required: txd=1 and busy=0 asynchronously, before the next clk edge; after release with a non-empty FIFO, the next fetch starts a clean frame with txd low for 4 cycles.
